spi_mem_burst: RTL and testbench

SPI_MEM_BURST -- requirements
Module: spi_mem_burst

---
 rtl/spi_mem_pkg.sv | 25 ++
 rtl/spi_mem_array.sv | 34 +++
 rtl/spi_mem_burst.sv | 207 ++++++++++++++++++++
 tb/tb_spi_mem_burst.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_mem_pkg
// Brief  : State encoding and command opcodes shared by the SPI burst memory.
// Rev    : 1.0  initial release
// ============================================================================
package spi_mem_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CMD     = 4'd1,
    LEN     = 4'd2,
    ADDR    = 4'd3,
    WDATA   = 4'd4,
    TURN    = 4'd5,
    RDATA   = 4'd6,
    DONE    = 4'd7,
    WAIT_CS = 4'd8
  } state_e;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/spi_mem_array.sv
`default_nettype none
// ============================================================================
// Module : spi_mem_array
// Brief  : DEPTH x DW storage, one synchronous write port, one async read port.
// Rev    : 1.0  initial release
// ============================================================================
module spi_mem_array #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  // Contents start at zero and are deliberately untouched by reset.
  logic [DW-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we_i && ({1'b0, waddr_i} < DEPTH_W)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = ({1'b0, raddr_i} < DEPTH_W) ? mem_q[raddr_i] : '0;

endmodule
`default_nettype wire

// File: rtl/spi_mem_burst.sv
`default_nettype none
// ============================================================================
// Module : spi_mem_burst
// Brief  : Serial burst read/write front end for a small word memory.
// Rev    : 1.0  initial release
// ============================================================================
module spi_mem_burst
  import spi_mem_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32,
  parameter int LW    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic mosi,
  output logic ready,
  output logic miso,
  output logic op_done,
  output logic err
);

  localparam int MAXW = (DW > AW) ? ((DW > LW) ? DW : LW) : ((AW > LW) ? AW : LW);
  localparam int CW   = $clog2(MAXW) + 1;

  localparam logic [CW-1:0] LAST_LEN_BIT  = CW'(LW - 1);
  localparam logic [CW-1:0] LAST_ADDR_BIT = CW'(AW - 1);
  localparam logic [CW-1:0] LAST_DATA_BIT = CW'(DW - 1);
  localparam logic [AW-1:0] LAST_ADDR     = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W       = (AW+1)'(DEPTH);

  state_e        state_q;
  logic          op_q;
  logic          valid_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] word_q;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] bit_q;
  logic [DW-1:0] sh_q;
  logic          ready_q, miso_q, op_done_q, err_q;

  logic [LW-1:0] len_in;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] wr_word;
  logic [DW-1:0] sh_next;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] rd_word;
  logic          we;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a >= LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  // Serial fields arrive LSB first, so each new bit enters at the top.
  assign len_in  = (len_q >> 1)  | (LW'(mosi) << (LW - 1));
  assign addr_in = (addr_q >> 1) | (AW'(mosi) << (AW - 1));
  assign wr_word = (sh_q >> 1)   | (DW'(mosi) << (DW - 1));
  assign sh_next = sh_q >> 1;

  assign we      = (state_q == WDATA) && !cs && valid_q && (bit_q == LAST_DATA_BIT);
  assign rd_addr = (state_q == TURN) ? addr_q : addr_inc(addr_q);
  assign rd_word = valid_q ? rd_data : '0;

  spi_mem_array #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (addr_q),
    .wdata_i (wr_word),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_READ;
      valid_q   <= 1'b0;
      len_q     <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      ready_q   <= 1'b0;
      miso_q    <= 1'b0;
      op_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      op_done_q <= 1'b0;
      err_q     <= 1'b0;
      if (cs && (state_q inside {CMD, LEN, ADDR, WDATA, TURN, RDATA})) begin
        state_q <= IDLE;
        err_q   <= 1'b1;
        ready_q <= 1'b0;
        miso_q  <= 1'b0;
        bit_q   <= '0;
        word_q  <= '0;
        sh_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            ready_q <= 1'b0;
            miso_q  <= 1'b0;
            if (!cs) begin
              state_q <= CMD;
              valid_q <= 1'b0;
              len_q   <= '0;
              addr_q  <= '0;
              word_q  <= '0;
              bit_q   <= '0;
              sh_q    <= '0;
            end
          end
          CMD: begin
            op_q    <= mosi ? OP_WRITE : OP_READ;
            state_q <= LEN;
          end
          LEN: begin
            len_q <= len_in;
            if (bit_q == LAST_LEN_BIT) begin
              bit_q   <= '0;
              state_q <= ADDR;
            end else begin
              bit_q <= bit_q + CW'(1);
            end
          end
          ADDR: begin
            addr_q <= addr_in;
            if (bit_q == LAST_ADDR_BIT) begin
              bit_q   <= '0;
              valid_q <= ({1'b0, addr_in} < DEPTH_W);
              state_q <= (op_q == OP_READ) ? TURN : WDATA;
            end else begin
              bit_q <= bit_q + CW'(1);
            end
          end
          WDATA: begin
            sh_q <= wr_word;
            if (bit_q == LAST_DATA_BIT) begin
              bit_q <= '0;
              if (word_q == len_q) begin
                state_q   <= DONE;
                op_done_q <= 1'b1;
                err_q     <= !valid_q;
              end else begin
                word_q <= word_q + LW'(1);
                addr_q <= addr_inc(addr_q);
              end
            end else begin
              bit_q <= bit_q + CW'(1);
            end
          end
          TURN: begin
            sh_q    <= rd_word;
            miso_q  <= rd_word[0];
            ready_q <= 1'b1;
            bit_q   <= '0;
            word_q  <= '0;
            state_q <= RDATA;
          end
          RDATA: begin
            if (bit_q == LAST_DATA_BIT) begin
              bit_q <= '0;
              if (word_q == len_q) begin
                state_q   <= DONE;
                ready_q   <= 1'b0;
                miso_q    <= 1'b0;
                op_done_q <= 1'b1;
                err_q     <= !valid_q;
              end else begin
                // Next word is fetched at the wrapped address so no gap cycle appears.
                word_q <= word_q + LW'(1);
                addr_q <= addr_inc(addr_q);
                sh_q   <= rd_word;
                miso_q <= rd_word[0];
              end
            end else begin
              sh_q   <= sh_next;
              miso_q <= sh_next[0];
              bit_q  <= bit_q + CW'(1);
            end
          end
          DONE: begin
            state_q <= WAIT_CS;
          end
          WAIT_CS: begin
            if (cs) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ready   = ready_q;
  assign miso    = miso_q;
  assign op_done = op_done_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_burst.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_mem_burst
// Brief  : Self-checking bench for spi_mem_burst (DEPTH 32 and DEPTH 24 copies).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_mem_burst;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cs_a = 1'b1, mosi_a = 1'b0, cs_b = 1'b1, mosi_b = 1'b0;
  logic ready_a, miso_a, op_done_a, err_a;
  logic ready_b, miso_b, op_done_b, err_b;

  always #5 clk = ~clk;

  spi_mem_burst #(.DW(8), .AW(5), .DEPTH(32), .LW(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs_a), .mosi(mosi_a),
    .ready(ready_a), .miso(miso_a), .op_done(op_done_a), .err(err_a)
  );

  spi_mem_burst #(.DW(8), .AW(5), .DEPTH(24), .LW(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(cs_b), .mosi(mosi_b),
    .ready(ready_b), .miso(miso_b), .op_done(op_done_b), .err(err_b)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  model_mem [2][32];
  logic [7:0]  wdata [8];
  logic [63:0] obs_bits;
  int          obs_ready, obs_runs, obs_done, obs_err, obs_both;
  logic        obs_rst_ready, obs_rst_miso;

  function automatic int depth_of(input int which);
    return (which != 0) ? 24 : 32;
  endfunction

  // Reference model: words land at (start+i) mod depth; out-of-range starts write nothing.
  function automatic void model_write(input int which, input int len, input int addr, input int nwords);
    if (addr < depth_of(which))
      for (int i = 0; i < nwords && i <= len; i++)
        model_mem[which][(addr + i) % depth_of(which)] = wdata[i];
  endfunction

  function automatic logic [63:0] model_read(input int which, input int len, input int addr);
    logic [63:0] v = '0;
    if (addr < depth_of(which))
      for (int i = 0; i <= len; i++)
        v[i*8 +: 8] = model_mem[which][(addr + i) % depth_of(which)];
    return v;
  endfunction

  task automatic set_pins(input int which, input logic c, input logic m);
    if (which != 0) begin cs_b = c; mosi_b = m; end
    else            begin cs_a = c; mosi_a = m; end
  endtask

  // Drives one frame and records what the selected DUT shows on its outputs.
  task automatic frame(input int which, input bit wr, input int len, input int addr,
                       input int abort_at, input int rst_at, input bit keep_low);
    int   nbits = (len + 1) * 8;
    int   last  = nbits + 16;
    bit   stop  = 1'b0;
    logic pr    = 1'b0;
    logic r, m, d, e, mo;
    obs_bits = '0; obs_ready = 0; obs_runs = 0; obs_done = 0; obs_err = 0; obs_both = 0;
    obs_rst_ready = 1'b0; obs_rst_miso = 1'b0;
    set_pins(which, 1'b1, 1'b0);
    @(negedge clk);
    set_pins(which, 1'b0, 1'b0);
    for (int t = 0; t < last + 3; t++) begin
      @(negedge clk);
      r = (which != 0) ? ready_b   : ready_a;
      m = (which != 0) ? miso_b    : miso_a;
      d = (which != 0) ? op_done_b : op_done_a;
      e = (which != 0) ? err_b     : err_a;
      if (r) begin
        if (obs_ready < 64) obs_bits[obs_ready] = m;
        obs_ready++;
        if (!pr) obs_runs++;
      end
      pr = r;
      if (d) obs_done++;
      if (e) obs_err++;
      if (d && e) obs_both++;
      if (rst_at >= 0 && t == rst_at + 1) begin
        obs_rst_ready = r; obs_rst_miso = m; rst_n = 1'b1; stop = 1'b1;
      end
      if (t == rst_at) rst_n = 1'b0;
      if (t == abort_at) stop = 1'b1;
      if (t == 0)                    mo = wr;
      else if (t < 4)                mo = 1'((len >> (t - 1)) & 1);
      else if (t < 9)                mo = 1'((addr >> (t - 4)) & 1);
      else if (wr && t - 9 < nbits)  mo = wdata[(t - 9) / 8][(t - 9) % 8];
      else                           mo = 1'($urandom);
      if (stop || (t >= last && !keep_low)) set_pins(which, 1'b1, mo);
      else                                  set_pins(which, 1'b0, mo);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++;
    if ({ready_a, miso_a, op_done_a, err_a, ready_b, miso_b, op_done_b, err_b} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {ready_a, miso_a, op_done_a, err_a, ready_b, miso_b, op_done_b, err_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    wdata[0] = 8'hA5;
    frame(0, 1'b1, 0, 3, -1, -1, 1'b0);
    model_write(0, 0, 3, 1);
    compared++;
    if (obs_done !== 1 || obs_err !== 0) begin
      mismatched++; $display("FAIL single_write: done=%0d err=%0d want 1/0", obs_done, obs_err);
    end
    frame(0, 1'b0, 0, 3, -1, -1, 1'b0);
    compared++;
    if (obs_bits[7:0] !== 8'hA5) begin
      mismatched++; $display("FAIL single_read_bits: got %h want a5", obs_bits[7:0]);
    end
    compared++;
    if (obs_ready !== 8 || obs_runs !== 1) begin
      mismatched++; $display("FAIL single_read_ready: cycles=%0d runs=%0d want 8/1", obs_ready, obs_runs);
    end
    compared++;
    if (obs_done !== 1 || obs_err !== 0) begin
      mismatched++; $display("FAIL single_read_done: done=%0d err=%0d want 1/0", obs_done, obs_err);
    end
  endtask

  task automatic test_burst_wrap;
    logic [63:0] exp;
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
    frame(0, 1'b1, 3, 30, -1, -1, 1'b0);
    model_write(0, 3, 30, 4);
    compared++;
    if (obs_done !== 1 || obs_err !== 0) begin
      mismatched++; $display("FAIL burst_write: done=%0d err=%0d want 1/0", obs_done, obs_err);
    end
    frame(0, 1'b0, 3, 30, -1, -1, 1'b0);
    exp = model_read(0, 3, 30);
    compared++;
    if (obs_bits !== exp || obs_ready !== 32 || obs_runs !== 1) begin
      mismatched++;
      $display("FAIL burst_read: got %h cycles=%0d runs=%0d want %h 32/1", obs_bits, obs_ready, obs_runs, exp);
    end
    frame(0, 1'b0, 0, 0, -1, -1, 1'b0);
    compared++;
    if (obs_bits[7:0] !== 8'h33) begin
      mismatched++; $display("FAIL wrap_addr0: got %h want 33", obs_bits[7:0]);
    end
  endtask

  task automatic test_invalid;
    wdata[0] = 8'hFF;
    frame(1, 1'b1, 0, 25, -1, -1, 1'b0);
    model_write(1, 0, 25, 1);
    compared++;
    if (obs_done !== 1 || obs_err !== 1 || obs_both !== 1) begin
      mismatched++;
      $display("FAIL invalid_write: done=%0d err=%0d same=%0d want 1/1/1", obs_done, obs_err, obs_both);
    end
    frame(1, 1'b0, 0, 25, -1, -1, 1'b0);
    compared++;
    if (obs_bits !== 64'h0 || obs_ready !== 8 || obs_both !== 1) begin
      mismatched++;
      $display("FAIL invalid_read: got %h cycles=%0d same=%0d want 0 8/1", obs_bits, obs_ready, obs_both);
    end
    frame(1, 1'b0, 0, 1, -1, -1, 1'b0);
    compared++;
    if (obs_bits[7:0] !== model_read(1, 0, 1) || obs_err !== 0) begin
      mismatched++; $display("FAIL invalid_untouched: got %h err=%0d want %h/0",
                             obs_bits[7:0], obs_err, model_read(1, 0, 1));
    end
  endtask

  task automatic test_abort;
    logic [63:0] exp;
    wdata[0] = 8'h77;
    frame(0, 1'b1, 0, 6, -1, -1, 1'b0);
    model_write(0, 0, 6, 1);
    wdata[0] = 8'h5A; wdata[1] = 8'hC3;
    frame(0, 1'b1, 1, 5, 21, -1, 1'b0);
    model_write(0, 1, 5, 1);
    compared++;
    if (obs_err !== 1 || obs_done !== 0) begin
      mismatched++; $display("FAIL abort_pulse: err=%0d done=%0d want 1/0", obs_err, obs_done);
    end
    frame(0, 1'b0, 1, 5, -1, -1, 1'b0);
    exp = model_read(0, 1, 5);
    compared++;
    if (obs_bits !== exp) begin
      mismatched++; $display("FAIL abort_commit: got %h want %h", obs_bits, exp);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] exp;
    frame(0, 1'b0, 1, 5, -1, 13, 1'b0);
    compared++;
    if (obs_rst_ready !== 1'b0 || obs_rst_miso !== 1'b0 || obs_done !== 0) begin
      mismatched++; $display("FAIL reset_mid: ready=%b miso=%b done=%0d want 0/0/0",
                             obs_rst_ready, obs_rst_miso, obs_done);
    end
    frame(0, 1'b0, 1, 5, -1, -1, 1'b0);
    exp = model_read(0, 1, 5);
    compared++;
    if (obs_bits !== exp || obs_done !== 1) begin
      mismatched++; $display("FAIL reset_keeps_mem: got %h done=%0d want %h/1", obs_bits, obs_done, exp);
    end
  endtask

  task automatic test_cs_hold;
    int act = 0;
    logic [63:0] exp;
    wdata[0] = 8'($urandom);
    frame(0, 1'b1, 0, 9, -1, -1, 1'b1);
    model_write(0, 0, 9, 1);
    compared++;
    if (obs_done !== 1) begin
      mismatched++; $display("FAIL hold_write_done: got %0d want 1", obs_done);
    end
    mosi_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_a || op_done_a || err_a) act++;
    end
    compared++;
    if (act !== 0) begin
      mismatched++; $display("FAIL hold_no_frame: active cycles=%0d want 0", act);
    end
    frame(0, 1'b0, 0, 9, -1, -1, 1'b0);
    exp = model_read(0, 0, 9);
    compared++;
    if (obs_bits !== exp || obs_done !== 1) begin
      mismatched++; $display("FAIL hold_new_frame: got %h done=%0d want %h/1", obs_bits, obs_done, exp);
    end
  endtask

  task automatic test_random;
    int which, len, addr, rlen, bad;
    logic [63:0] exp;
    for (int n = 0; n < 12; n++) begin
      which = int'($urandom_range(0, 1));
      len   = int'($urandom_range(0, 7));
      addr  = int'($urandom_range(0, 31));
      bad   = (addr >= depth_of(which)) ? 1 : 0;
      for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom);
      frame(which, 1'b1, len, addr, -1, -1, 1'b0);
      model_write(which, len, addr, len + 1);
      compared++;
      if (obs_done !== 1 || obs_err !== bad) begin
        mismatched++; $display("FAIL rand_write[%0d]: done=%0d err=%0d want 1/%0d", n, obs_done, obs_err, bad);
      end
      rlen = int'($urandom_range(0, 7));
      frame(which, 1'b0, rlen, addr, -1, -1, 1'b0);
      exp = model_read(which, rlen, addr);
      compared++;
      if (obs_bits !== exp || obs_ready !== (rlen + 1) * 8 || obs_err !== bad || obs_done !== 1) begin
        mismatched++;
        $display("FAIL rand_read[%0d]: got %h cycles=%0d err=%0d want %h %0d/%0d",
                 n, obs_bits, obs_ready, obs_err, exp, (rlen + 1) * 8, bad);
      end
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 32; i++) model_mem[w][i] = 8'h00;
    test_reset();
    test_single();
    test_burst_wrap();
    test_invalid();
    test_abort();
    test_reset_mid();
    test_cs_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
